// File: rtl/uart_ser_buffered.sv
// uart_ser_buffered
// Double-buffered parallel-to-serial converter for the UART TX datapath.
// A word is accepted into a holding register through a Data_Valid/ser_ready
// handshake, then moved into a shift register and sent out one bit per
// ser_en cycle. The holding register lets the next word be loaded while the
// current one is still shifting, so consecutive words leave with no idle bit
// between them. ser_clr flushes both stages synchronously.
//
// Optional build feature: define UART_SER_PARITY_EN to add the par_type
// input and the par_bit output, which carries the parity of the word that is
// currently shifting.
module uart_ser_buffered #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    output logic                  ser_ready,
    input  logic                  msb_first,
    input  logic                  ser_en,
    input  logic                  ser_clr,
`ifdef UART_SER_PARITY_EN
    input  logic                  par_type,
    output logic                  par_bit,
`endif
    output logic                  ser_data,
    output logic                  ser_busy,
    output logic                  ser_done
);

    // Bit counter only has to reach DATA_WIDTH-1; keep it at least 1 bit wide.
    localparam int              CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    // Holding stage: the next word waiting to be shifted.
    logic [DATA_WIDTH-1:0] hold_reg,    hold_reg_nxt;
    logic                  hold_ord,    hold_ord_nxt;
    logic                  hold_full,   hold_full_nxt;

    // Shift stage: the word currently on the serial line.
    logic [DATA_WIDTH-1:0] shift_reg,   shift_reg_nxt;
    logic                  ord,         ord_nxt;
    logic                  shift_valid, shift_valid_nxt;
    logic [CNT_W-1:0]      counter,     counter_nxt;

    // Per-cycle events.
    logic accept;     // source word captured into the holding register
    logic last_bit;   // the final bit of the shifting word is consumed now
    logic advance;    // a non-final bit is consumed now
    logic transfer;   // holding register moves into the shift register

    assign accept   = Data_Valid && !hold_full;
    assign last_bit = ser_en && shift_valid && (counter == LAST_CNT);
    assign advance  = ser_en && shift_valid && !last_bit;
    // Refill the shifter when it is empty, or exactly as its last bit leaves.
    assign transfer = hold_full && (!shift_valid || last_bit);

    // Handshake and serial outputs; ser_ready comes straight from a flop.
    assign ser_ready = !hold_full;
    assign ser_busy  = shift_valid;
    assign ser_done  = last_bit && !ser_clr;
    assign ser_data  = shift_valid ? (ord ? shift_reg[DATA_WIDTH-1] : shift_reg[0]) : 1'b0;

`ifdef UART_SER_PARITY_EN
    logic hold_par, hold_par_nxt;
    logic par_q,    par_q_nxt;

    assign par_bit = par_q;
`endif

    // Next-state logic: flush beats accept, transfer and shift.
    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        hold_reg_nxt    = hold_reg;
        hold_ord_nxt    = hold_ord;
        hold_full_nxt   = hold_full;
        shift_reg_nxt   = shift_reg;
        ord_nxt         = ord;
        shift_valid_nxt = shift_valid;
        counter_nxt     = counter;
`ifdef UART_SER_PARITY_EN
        hold_par_nxt    = hold_par;
        par_q_nxt       = par_q;
`endif

        if (ser_clr) begin
            // Drop both stages and any word offered this cycle.
            hold_full_nxt   = 1'b0;
            shift_valid_nxt = 1'b0;
            counter_nxt     = '0;
`ifdef UART_SER_PARITY_EN
            par_q_nxt       = 1'b0;
`endif
        end else begin
            // Accept and transfer are exclusive: accept needs an empty holder,
            // transfer needs a full one. A word accepted now transfers next cycle.
            if (accept) begin
                hold_reg_nxt  = P_DATA;
                hold_ord_nxt  = msb_first;
                hold_full_nxt = 1'b1;
`ifdef UART_SER_PARITY_EN
                hold_par_nxt  = (^P_DATA) ^ par_type;
`endif
            end

            if (transfer) begin
                shift_reg_nxt   = hold_reg;
                ord_nxt         = hold_ord;
                shift_valid_nxt = 1'b1;
                counter_nxt     = '0;
                hold_full_nxt   = 1'b0;
`ifdef UART_SER_PARITY_EN
                par_q_nxt       = hold_par;
`endif
            end else if (last_bit) begin
                // Word finished and nothing queued behind it.
                shift_valid_nxt = 1'b0;
                counter_nxt     = '0;
            end else if (advance) begin
                // Move the next bit to the output end, zero filling behind it.
                counter_nxt   = counter + CNT_W'(1);
                shift_reg_nxt = ord ? (shift_reg << 1) : (shift_reg >> 1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_reg    <= '0;
            hold_ord    <= 1'b0;
            hold_full   <= 1'b0;
            shift_reg   <= '0;
            ord         <= 1'b0;
            shift_valid <= 1'b0;
            counter     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
            hold_reg    <= hold_reg_nxt;
            hold_ord    <= hold_ord_nxt;
            hold_full   <= hold_full_nxt;
            shift_reg   <= shift_reg_nxt;
            ord         <= ord_nxt;
            shift_valid <= shift_valid_nxt;
            counter     <= counter_nxt;
        end
    end

`ifdef UART_SER_PARITY_EN
    // Parity registers: captured with the word, presented while it shifts.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_par <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            hold_par <= hold_par_nxt;
            par_q    <= par_q_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_uart_ser_buffered.sv
// tb_uart_ser_buffered
// Self-checking bench for uart_ser_buffered (DATA_WIDTH = 8): a constant
// vector table for single words, hand-written corner sequences, and a random
// run checked against a queue-based reference model of the serializer.
// Parity checks are compiled in when UART_SER_PARITY_EN is defined.
module tb_uart_ser_buffered;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          ser_ready;
    logic          msb_first;
    logic          ser_en;
    logic          ser_clr;
    logic          ser_data;
    logic          ser_busy;
    logic          ser_done;
`ifdef UART_SER_PARITY_EN
    logic          par_type;
    logic          par_bit;
`endif

    int checks = 0;
    int errors = 0;

    uart_ser_buffered #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .ser_ready  (ser_ready),
        .msb_first  (msb_first),
        .ser_en     (ser_en),
        .ser_clr    (ser_clr),
`ifdef UART_SER_PARITY_EN
        .par_type   (par_type),
        .par_bit    (par_bit),
`endif
        .ser_data   (ser_data),
        .ser_busy   (ser_busy),
        .ser_done   (ser_done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // pend: the single queued word; cur: bits still to be sent, in wire order.
    logic    pend_v = 1'b0;
    logic [DW-1:0] pend_w;
    logic    pend_o;
    logic    pend_p;
    logic    cur_bits[$];
    logic    cur_p = 1'b0;
    logic    ptype = 1'b0;

    function automatic logic parity_of(input logic [DW-1:0] w, input logic t);
        return (^w) ^ t;
    endfunction

    task automatic model_clear();
        pend_v = 1'b0;
        cur_bits.delete();
    endtask

    // Drive one cycle's inputs at the falling edge and settle before sampling.
    task automatic drive(input logic dv, input logic [DW-1:0] d, input logic msb,
                         input logic en, input logic clr);
        @(negedge CLK);
        Data_Valid = dv;
        P_DATA     = d;
        msb_first  = msb;
        ser_en     = en;
        ser_clr    = clr;
`ifdef UART_SER_PARITY_EN
        par_type   = ptype;
`endif
        #1;
    endtask

    // One cycle checked against the model, then the model advances.
    task automatic cycle(input logic dv, input logic [DW-1:0] d, input logic msb,
                         input logic en, input logic clr);
        logic had_pend;
        drive(dv, d, msb, en, clr);
        check("ready", ser_ready, !pend_v);
        check("busy",  ser_busy,  cur_bits.size() > 0);
        check("data",  ser_data,  (cur_bits.size() > 0) ? cur_bits[0] : 1'b0);
        check("done",  ser_done,  !clr && en && cur_bits.size() == 1);
`ifdef UART_SER_PARITY_EN
        if (cur_bits.size() > 0) check("par", par_bit, cur_p);
`endif
        if (clr) begin
            model_clear();
        end else begin
            had_pend = pend_v;
            if (en && cur_bits.size() > 0) void'(cur_bits.pop_front());
            if (had_pend && cur_bits.size() == 0) begin
                for (int i = 0; i < DW; i++)
                    cur_bits.push_back(pend_o ? pend_w[DW-1-i] : pend_w[i]);
                cur_p  = pend_p;
                pend_v = 1'b0;
            end
            if (dv && !had_pend) begin
                pend_v = 1'b1;
                pend_w = d;
                pend_o = msb;
                pend_p = parity_of(d, ptype);
            end
        end
    endtask

    // ---------------- vector table ----------------
    // exp[i] is the i-th bit expected on ser_data.
    typedef struct {
        logic [DW-1:0] data;
        logic          msb;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[5];

    logic [15:0] stream;
    logic [15:0] done_mask;
    int          en_count;
    int          done_at;

    initial begin
        vecs[0] = '{data: 8'hA5, msb: 1'b0, exp: 8'hA5};
        vecs[1] = '{data: 8'hA5, msb: 1'b1, exp: 8'hA5};
        vecs[2] = '{data: 8'h01, msb: 1'b1, exp: 8'h80};
        vecs[3] = '{data: 8'h0F, msb: 1'b0, exp: 8'h0F};
        vecs[4] = '{data: 8'h0F, msb: 1'b1, exp: 8'hF0};

        RST = 1'b0; Data_Valid = 1'b0; P_DATA = '0; msb_first = 1'b0;
        ser_en = 1'b0; ser_clr = 1'b0;
`ifdef UART_SER_PARITY_EN
        par_type = 1'b0;
`endif
        #12;
        check("rst_ready", ser_ready, 1'b1);
        check("rst_busy",  ser_busy,  1'b0);
        check("rst_data",  ser_data,  1'b0);
        check("rst_done",  ser_done,  1'b0);
        @(negedge CLK);
        RST = 1'b1;

        // Single words from the table, ser_en held high throughout.
        for (int v = 0; v < 5; v++) begin
            drive(1'b1, vecs[v].data, vecs[v].msb, 1'b1, 1'b0);
            check("tbl_idle_done", ser_done, 1'b0);
            check("tbl_idle_ready", ser_ready, 1'b1);
            drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            check("tbl_held_ready", ser_ready, 1'b0);
            check("tbl_held_busy", ser_busy, 1'b0);
            for (int i = 0; i < DW; i++) begin
                drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
                check("tbl_bit", ser_data, vecs[v].exp[i]);
                check("tbl_done", ser_done, i == DW - 1);
            end
            drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            check("tbl_end_busy", ser_busy, 1'b0);
            check("tbl_end_ready", ser_ready, 1'b1);
        end

        // Back-to-back: FF then 00 with no gap, done pulses 8 cycles apart.
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        stream = '0; done_mask = '0;
        for (int i = 0; i < 16; i++) begin
            cycle(i == 0, 8'h00, 1'b0, 1'b1, 1'b0);
            stream[i]    = ser_data;
            done_mask[i] = ser_done;
            if (i == 8) check("b2b_ready_after", ser_ready, 1'b1);
        end
        check("b2b_stream", stream, 16'h00FF);
        check("b2b_done", done_mask, 16'h8080);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Pause: ser_en 1,1,0,0,1,... done after exactly 8 enabled cycles.
        cycle(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        en_count = 0; done_at = -1;
        for (int i = 0; i < 12; i++) begin
            logic en;
            en = !(i == 2 || i == 3);
            cycle(1'b0, 8'h00, 1'b0, en, 1'b0);
            if (en) en_count++;
            if (ser_done && done_at < 0) done_at = en_count;
        end
        check("pause_done_at", done_at, 8);

        // Flush mid-word with the holder full and a new word offered.
        cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("flush_pre_ready", ser_ready, 1'b0);
        cycle(1'b1, 8'h5A, 1'b0, 1'b1, 1'b1);
        check("flush_cycle_done", ser_done, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("flush_after_busy", ser_busy, 1'b0);

        // Asynchronous reset mid-word.
        cycle(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        #1;
        RST = 1'b0;
        #1;
        check("arst_busy",  ser_busy,  1'b0);
        check("arst_ready", ser_ready, 1'b1);
        check("arst_data",  ser_data,  1'b0);
        check("arst_done",  ser_done,  1'b0);
        model_clear();
        @(negedge CLK);
        RST = 1'b1;

`ifdef UART_SER_PARITY_EN
        // Parity of 8'h07 (three ones): even -> 1, odd -> 0, stable all word.
        for (int t = 0; t < 2; t++) begin
            ptype = t[0];
            cycle(1'b1, 8'h07, 1'b0, 1'b1, 1'b0);
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            for (int i = 0; i < DW; i++) begin
                cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
                check("par_07", par_bit, t == 0);
            end
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("par_clr", par_bit, 1'b0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            ptype = 1'($urandom_range(0, 1));
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
